// File: rtl/dest_matcher.sv
// dest_matcher: latches a destination command, enables motion (go) until a
// barcode ID equal to the destination is seen, then pulses arrived. A piezo
// buzzer is driven with a complementary square wave while in transit.
module dest_matcher #(
    parameter int unsigned BUZZ_HALF = 25000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cmd,
    input  logic       cmd_rdy,
    output logic       clr_cmd_rdy,
    input  logic [7:0] ID,
    input  logic       ID_vld,
    output logic       clr_ID_vld,
    output logic       go,
    output logic       in_transit,
    output logic       arrived,
    output logic       buzz,
    output logic       buzz_n
);

    localparam int unsigned CW = (BUZZ_HALF > 1) ? $clog2(BUZZ_HALF) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BUZZ_HALF - 1);

    localparam logic [1:0] OP_STOP = 2'b00;
    localparam logic [1:0] OP_GO   = 2'b01;

    typedef enum logic {
        IDLE    = 1'b0,
        TRANSIT = 1'b1
    } state_t;

    state_t          state;
    state_t          nxt_state;
    logic [5:0]      dest;
    logic            nxt_go;
    logic            match_event;
    logic            load_dest;
    logic [CW-1:0]   buzz_cnt;

    // ID[7:6] are always 00 when valid; only the low six bits are compared.
    logic            id_hi_unused;
    assign id_hi_unused = ^ID[7:6];

    // Next-state decode and handshake acks; a pending command beats a pending ID.
    always_comb begin
        clr_cmd_rdy = 1'b0;
        clr_ID_vld  = 1'b0;
        nxt_state   = state;
        nxt_go      = go;
        match_event = 1'b0;
        load_dest   = 1'b0;
        if (!rst) begin
            if (cmd_rdy) begin
                clr_cmd_rdy = 1'b1;
                case (cmd[7:6])
                    OP_GO: begin
                        load_dest = 1'b1;
                        nxt_go    = 1'b1;
                        nxt_state = TRANSIT;
                    end
                    OP_STOP: begin
                        nxt_go    = 1'b0;
                        nxt_state = IDLE;
                    end
                    default: ;
                endcase
            end else if (ID_vld) begin
                clr_ID_vld = 1'b1;
                if ((state == TRANSIT) && (ID[5:0] == dest)) begin
                    match_event = 1'b1;
                    nxt_go      = 1'b0;
                    nxt_state   = IDLE;
                end
            end
        end
    end

    // State, destination and registered outputs, including the buzzer phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            dest       <= '0;
            go         <= 1'b0;
            in_transit <= 1'b0;
            arrived    <= 1'b0;
            buzz       <= 1'b0;
            buzz_n     <= 1'b0;
            buzz_cnt   <= '0;
        end else begin
            state      <= nxt_state;
            go         <= nxt_go;
            in_transit <= (nxt_state == TRANSIT);
            arrived    <= match_event;
            if (load_dest) begin
                dest <= cmd[5:0];
            end
            if (nxt_state == TRANSIT) begin
                // A redirect while already moving keeps the running phase.
                if (state == IDLE) begin
                    buzz_cnt <= '0;
                    buzz     <= 1'b1;
                    buzz_n   <= 1'b0;
                end else if (buzz_cnt == CNT_LAST) begin
                    buzz_cnt <= '0;
                    buzz     <= ~buzz;
                    buzz_n   <= ~buzz_n;
                end else begin
                    buzz_cnt <= buzz_cnt + 1'b1;
                end
            end else begin
                buzz_cnt <= '0;
                buzz     <= 1'b0;
                buzz_n   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dest_matcher.sv
// Bench for dest_matcher: directed vector table, a buzzer phase sequence and
// randomized traffic compared against a behavioural model.
module tb_dest_matcher;

    localparam int unsigned BH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] cmd;
    logic       cmd_rdy;
    logic       clr_cmd_rdy;
    logic [7:0] ID;
    logic       ID_vld;
    logic       clr_ID_vld;
    logic       go;
    logic       in_transit;
    logic       arrived;
    logic       buzz;
    logic       buzz_n;

    int errors = 0;
    int checks = 0;

    // model state
    bit          m_moving = 1'b0;
    logic [5:0]  m_dest = '0;
    int unsigned m_t = 0;
    bit          m_arr = 1'b0;

    dest_matcher #(.BUZZ_HALF(BH)) dut (
        .clk(clk), .rst(rst),
        .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
        .ID(ID), .ID_vld(ID_vld), .clr_ID_vld(clr_ID_vld),
        .go(go), .in_transit(in_transit), .arrived(arrived),
        .buzz(buzz), .buzz_n(buzz_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // exp bits: {clr_cmd_rdy, clr_ID_vld, go, in_transit, arrived, buzz, buzz_n}
    typedef struct {
        logic       r;
        logic [7:0] c;
        logic       cr;
        logic [7:0] i;
        logic       iv;
        logic [6:0] exp;
    } vec_t;

    function automatic vec_t mk(logic r, logic [7:0] c, logic cr, logic [7:0] i,
                                logic iv, logic [6:0] exp);
        vec_t x;
        x.r = r; x.c = c; x.cr = cr; x.i = i; x.iv = iv; x.exp = exp;
        return x;
    endfunction

    task automatic model_step(input logic r, input logic [7:0] c, input logic cr,
                              input logic [7:0] i, input logic iv, input string tag,
                              output logic ack_c, output logic ack_i);
        bit   was;
        logic exp_bz;
        rst = r; cmd = c; cmd_rdy = cr; ID = i; ID_vld = iv;
        #1;
        ack_c = cr && !r;
        ack_i = iv && !cr && !r;
        chk($sformatf("%s.clr_cmd_rdy", tag), clr_cmd_rdy, ack_c);
        chk($sformatf("%s.clr_ID_vld", tag), clr_ID_vld, ack_i);
        was   = m_moving;
        m_arr = 1'b0;
        if (r) begin
            m_moving = 1'b0;
            m_dest   = '0;
        end else if (cr) begin
            if (c[7:6] == 2'b01) begin
                m_dest   = c[5:0];
                m_moving = 1'b1;
            end else if (c[7:6] == 2'b00) begin
                m_moving = 1'b0;
            end
        end else if (iv && m_moving && (i[5:0] == m_dest)) begin
            m_moving = 1'b0;
            m_arr    = 1'b1;
        end
        if (m_moving && was) m_t++;
        else m_t = 0;
        @(posedge clk);
        #1;
        exp_bz = m_moving && (((m_t / BH) % 2) == 0);
        chk($sformatf("%s.go", tag), go, m_moving);
        chk($sformatf("%s.in_transit", tag), in_transit, m_moving);
        chk($sformatf("%s.arrived", tag), arrived, m_arr);
        chk($sformatf("%s.buzz", tag), buzz, exp_bz);
        chk($sformatf("%s.buzz_n", tag), buzz_n, m_moving && !exp_bz);
    endtask

    initial begin
        vec_t vecs[25];
        logic ac, ai;
        logic p_cmd, p_id, r;
        logic [7:0] p_c, p_i;
        logic [6:0] e;

        vecs[0]  = mk(1, 8'h00, 0, 8'h00, 0, 7'b0000000);
        vecs[1]  = mk(1, 8'h45, 1, 8'h05, 1, 7'b0000000);
        vecs[2]  = mk(0, 8'h45, 1, 8'h00, 0, 7'b1011010);
        vecs[3]  = mk(0, 8'h00, 0, 8'h00, 0, 7'b0011010);
        vecs[4]  = mk(0, 8'h00, 0, 8'h03, 1, 7'b0111010);
        vecs[5]  = mk(0, 8'h00, 0, 8'h05, 1, 7'b0100100);
        vecs[6]  = mk(0, 8'h00, 0, 8'h00, 0, 7'b0000000);
        vecs[7]  = mk(0, 8'h45, 1, 8'h00, 0, 7'b1011010);
        vecs[8]  = mk(0, 8'h45, 1, 8'h05, 1, 7'b1011010);
        vecs[9]  = mk(0, 8'h00, 0, 8'h05, 1, 7'b0100100);
        vecs[10] = mk(0, 8'h00, 0, 8'h00, 0, 7'b0000000);
        vecs[11] = mk(0, 8'h47, 1, 8'h00, 0, 7'b1011010);
        vecs[12] = mk(0, 8'h00, 1, 8'h00, 0, 7'b1000000);
        vecs[13] = mk(0, 8'h00, 0, 8'h07, 1, 7'b0100000);
        vecs[14] = mk(0, 8'h85, 1, 8'h00, 0, 7'b1000000);
        vecs[15] = mk(0, 8'hC5, 1, 8'h00, 0, 7'b1000000);
        vecs[16] = mk(0, 8'h45, 1, 8'h00, 0, 7'b1011010);
        vecs[17] = mk(0, 8'h00, 0, 8'h00, 0, 7'b0011010);
        vecs[18] = mk(1, 8'h00, 0, 8'h05, 1, 7'b0000000);
        vecs[19] = mk(0, 8'h00, 0, 8'h05, 1, 7'b0100000);
        vecs[20] = mk(0, 8'h45, 1, 8'h00, 0, 7'b1011010);
        vecs[21] = mk(0, 8'h87, 1, 8'h00, 0, 7'b1011010);
        vecs[22] = mk(0, 8'h00, 0, 8'h07, 1, 7'b0111010);
        vecs[23] = mk(0, 8'h00, 0, 8'h05, 1, 7'b0100100);
        vecs[24] = mk(0, 8'h00, 0, 8'h00, 0, 7'b0000000);

        // directed table
        for (int k = 0; k < 25; k++) begin
            rst = vecs[k].r; cmd = vecs[k].c; cmd_rdy = vecs[k].cr;
            ID = vecs[k].i; ID_vld = vecs[k].iv;
            e = vecs[k].exp;
            #1;
            chk($sformatf("vec%0d.clr_cmd_rdy", k), clr_cmd_rdy, e[6]);
            chk($sformatf("vec%0d.clr_ID_vld", k), clr_ID_vld, e[5]);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d.go", k), go, e[4]);
            chk($sformatf("vec%0d.in_transit", k), in_transit, e[3]);
            chk($sformatf("vec%0d.arrived", k), arrived, e[2]);
            chk($sformatf("vec%0d.buzz", k), buzz, e[1]);
            chk($sformatf("vec%0d.buzz_n", k), buzz_n, e[0]);
        end

        // buzzer phase across a redirect
        model_step(1, 8'h00, 0, 8'h00, 0, "bz_rst", ac, ai);
        model_step(0, 8'h45, 1, 8'h00, 0, "bz_go", ac, ai);
        for (int k = 0; k < 6; k++) model_step(0, 8'h00, 0, 8'h00, 0, "bz_run", ac, ai);
        model_step(0, 8'h47, 1, 8'h00, 0, "bz_redir", ac, ai);
        for (int k = 0; k < 10; k++) model_step(0, 8'h00, 0, 8'h00, 0, "bz_run2", ac, ai);
        model_step(0, 8'h00, 0, 8'h07, 1, "bz_match", ac, ai);

        // randomized traffic with rdy/vld held until acked
        p_cmd = 0; p_id = 0; p_c = '0; p_i = '0;
        for (int n = 0; n < 600; n++) begin
            if (!p_cmd && ($urandom_range(0, 4) == 0)) begin
                p_cmd = 1;
                p_c[7:6] = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(2, 3))
                                                        : 2'($urandom_range(0, 1));
                p_c[5:0] = 6'($urandom_range(0, 7));
            end
            if (!p_id && ($urandom_range(0, 2) == 0)) begin
                p_id = 1;
                p_i  = {2'b00, 6'($urandom_range(0, 7))};
            end
            r = ($urandom_range(0, 49) == 0);
            model_step(r, p_c, p_cmd, p_i, p_id, "rnd", ac, ai);
            if (ac) p_cmd = 0;
            if (ai) p_id = 0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
